// File: rtl/input_buffer_array_if.sv
// Row-FIFO bus for input_buffer_array: push/pop requests, head row, skewed wavefront and status.
interface input_buffer_array_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned ADDR_WIDTH = 3
);
   localparam int unsigned ROW_W = NUM_LANES * DATA_WIDTH;

   logic                 i_wr;
   logic [ROW_W-1:0]     i_wr_data;
   logic                 i_rd;
   logic                 i_flush;
   logic                 i_clr_err;
   logic [ROW_W-1:0]     o_head_data;
   logic [ROW_W-1:0]     o_skew_data;
   logic [NUM_LANES-1:0] o_skew_valid;
   logic [ADDR_WIDTH:0]  o_count;
   logic                 o_is_empty;
   logic                 o_is_full;
   logic                 o_almost_full;
   logic                 o_almost_empty;
   logic                 o_overflow;
   logic                 o_underflow;

   modport master (
      output i_wr, i_wr_data, i_rd, i_flush, i_clr_err,
      input  o_head_data, o_skew_data, o_skew_valid, o_count, o_is_empty, o_is_full,
      input  o_almost_full, o_almost_empty, o_overflow, o_underflow
   );

   modport slave (
      input  i_wr, i_wr_data, i_rd, i_flush, i_clr_err,
      output o_head_data, o_skew_data, o_skew_valid, o_count, o_is_empty, o_is_full,
      output o_almost_full, o_almost_empty, o_overflow, o_underflow
   );
endinterface

// File: rtl/input_buffer_array.sv
// Multi-lane row FIFO feeding one systolic-array edge, with a diagonally skewed pop output
// (lane k delayed k+1 cycles), occupancy flags and sticky error flags.
module input_buffer_array #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AF_THRESH  = 6,
   parameter int unsigned AE_THRESH  = 1
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   input_buffer_array_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned ROW_W = NUM_LANES * DATA_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("AF_THRESH must lie in 1..DEPTH");
   end
   if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("AE_THRESH must lie in 0..DEPTH-1");
   end
   if (NUM_LANES < 1) begin : g_bad_lanes
      $error("NUM_LANES must be at least 1");
   end

   logic [ROW_W-1:0]      mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic                  is_empty, is_full;
   logic                  rd_accept, wr_accept, do_rd, do_wr;
   logic [ROW_W-1:0]      head_data;

   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] skew_data;
   logic [NUM_LANES-1:0]                 skew_valid;

   assign is_empty  = (count_q == '0);
   assign is_full   = (count_q == DEPTH_C);
   assign rd_accept = bus.i_rd && !is_empty;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired write.
   assign wr_accept = bus.i_wr && (!is_full || rd_accept);
   assign do_rd     = rd_accept && !bus.i_flush;
   assign do_wr     = wr_accept && !bus.i_flush;
   assign head_data = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Set beats clear when both happen in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (bus.i_clr_err) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (bus.i_wr && !wr_accept && !bus.i_flush) ovf_d = 1'b1;
      if (bus.i_rd && is_empty && !bus.i_flush)   udf_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
         if (bus.i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (do_wr) begin
               mem_q[wr_ptr_q] <= bus.i_wr_data;
               wr_ptr_q        <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            count_q <= count_d;
         end
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic [DATA_WIDTH-1:0] sd_q [k+1];
      logic                  sv_q [k+1];

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            for (int j = 0; j <= k; j++) begin
               sd_q[j] <= '0;
               sv_q[j] <= 1'b0;
            end
         end else if (bus.i_flush) begin
            for (int j = 0; j <= k; j++) sv_q[j] <= 1'b0;
         end else begin
            sd_q[0] <= head_data[k*DATA_WIDTH +: DATA_WIDTH];
            sv_q[0] <= rd_accept;
            for (int j = 1; j <= k; j++) begin
               sd_q[j] <= sd_q[j-1];
               sv_q[j] <= sv_q[j-1];
            end
         end
      end

      assign skew_data[k]  = sd_q[k];
      assign skew_valid[k] = sv_q[k];
   end

   assign bus.o_head_data    = head_data;
   assign bus.o_skew_data    = skew_data;
   assign bus.o_skew_valid   = skew_valid;
   assign bus.o_count        = count_q;
   assign bus.o_is_empty     = is_empty;
   assign bus.o_is_full      = is_full;
   assign bus.o_almost_full  = (count_q >= AF_C);
   assign bus.o_almost_empty = (count_q <= AE_C);
   assign bus.o_overflow     = ovf_q;
   assign bus.o_underflow    = udf_q;
endmodule

// File: doc/input_buffer_array.md
Name: input_buffer_array

Overview:
Multi-lane row FIFO that feeds one edge of the systolic array. Each write pushes one row of NUM_LANES elements and each read pops one row. All 2**ADDR_WIDTH entries are usable, with occupancy count, programmable almost-full/almost-empty flags, flush, and sticky overflow/underflow error flags. The popped row is also presented on a diagonally skewed output: lane k is delayed k+1 cycles, which is the wavefront timing the PE array needs.

Parameters:
DATA_WIDTH, 8, width of one lane element
NUM_LANES, 4, number of lanes per row (PE array edge length)
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH rows, all usable
AF_THRESH, 6, o_almost_full asserted when count >= AF_THRESH
AE_THRESH, 1, o_almost_empty asserted when count <= AE_THRESH

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  reset, synchronous, active-low
i_wr  in  1  push request
i_wr_data  in  NUM_LANES*DATA_WIDTH  row to push; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
i_rd  in  1  pop request
i_flush  in  1  synchronous clear of FIFO contents and skew pipeline
i_clr_err  in  1  clears sticky error flags
o_head_data  out  NUM_LANES*DATA_WIDTH  head row, first-word-fall-through (combinational from memory)
o_skew_data  out  NUM_LANES*DATA_WIDTH  skewed popped rows, registered
o_skew_valid  out  NUM_LANES  per-lane valid for o_skew_data
o_count  out  ADDR_WIDTH+1  rows stored, 0..DEPTH
o_is_empty  out  1  count == 0
o_is_full  out  1  count == DEPTH
o_almost_full  out  1  count >= AF_THRESH
o_almost_empty  out  1  count <= AE_THRESH
o_overflow  out  1  sticky: write rejected
o_underflow  out  1  sticky: read rejected

Behaviour:
- Reset (i_rst_n=0 at clock edge) clears rd/wr pointers and count, zeroes all memory rows and skew registers, and clears o_skew_valid and both error flags.
- Values after reset: o_head_data=0, o_count=0, o_is_empty=1, o_is_full=0, o_almost_empty=1, o_almost_full=0.
- rd_accept = i_rd && !o_is_empty.
- wr_accept = i_wr && (!o_is_full || rd_accept). On full, a simultaneous read and write both succeed and count is unchanged.
- On empty, a simultaneous read and write: the read is rejected (underflow set) and the write is accepted, so count becomes 1.
- Accepted write: mem[wr_ptr] <= i_wr_data; wr_ptr increments and wraps DEPTH-1 -> 0.
- Accepted read: rd_ptr increments and wraps the same way. o_head_data = mem[rd_ptr] at all times, with zero latency.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither. Flags are combinational from count.
- Skew pipeline: lane k has a shift chain of k+1 registers that advances every cycle, whether or not a read occurs.
- Stage 0 of lane k loads {rd_accept, mem[rd_ptr] lane k}, so valid=0 on a cycle with no accepted pop.
- o_skew_data lane k and o_skew_valid[k] come from the last stage of its chain. A row popped in cycle t therefore appears on lane k in cycle t+k+1.
- i_flush (when reset is inactive) clears pointers, count and all skew valid bits. Memory contents are kept. Flush has priority over i_rd and i_wr in the same cycle: the write is dropped and no error flag is set.
- o_overflow is set on i_wr && !wr_accept && !i_flush. o_underflow is set on i_rd && o_is_empty && !i_flush.
- Error flags hold until reset or i_clr_err. If i_clr_err and a new error occur in the same cycle, set wins.
- Reset asserted mid-operation overrides everything, including flush, and discards in-flight skew data.
- Parameter checks at elaboration: AF_THRESH in 1..DEPTH, AE_THRESH in 0..DEPTH-1, NUM_LANES >= 1.

Test Plan:
1. Reset, then push rows 0x04030201, 0x08070605 (lane0 = LSB) -> o_count=2, o_head_data=0x04030201, o_almost_empty=0.
2. Push 8 rows into an empty FIFO -> after the 8th push o_count=8, o_is_full=1, o_almost_full=1 from count 6. A 9th push -> o_count=8, o_overflow=1.
3. Pop once from empty -> o_underflow=1, o_count=0. Assert i_clr_err one cycle -> o_underflow=0.
4. Full FIFO with i_rd=i_wr=1 on the same cycle for 20 cycles using an incrementing pattern -> o_count stays 8, pointers wrap, and pops come out in push order with no loss.
5. Pop row 0x04030201 in cycle t with no further pops -> lane0=0x01 valid at t+1, lane1=0x02 at t+2, lane2=0x03 at t+3, lane3=0x04 at t+4, each valid for exactly one cycle.
6. With 5 rows stored and a pop in flight in the skew chain, assert i_flush together with i_wr -> next cycle o_count=0, o_is_empty=1, all o_skew_valid=0, o_overflow=0.
